// File: rtl/arbitro_insercion_rr_if.sv
// Bus between the write producers, the round-robin insertion arbiter and the circular buffer.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface arbitro_insercion_rr_if #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4,
    parameter int IDX   = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]       req_i;
    logic [NREQ*WIDTH-1:0] dato_req_i;
    logic [NREQ-1:0]       ack_o;
    logic                  insercion_o;
    logic [WIDTH-1:0]      dato_o;
    logic                  llena_i;
    logic [IDX-1:0]        grant_o;
    logic                  ocupado_o;

    modport slave (
        input  req_i, dato_req_i, llena_i,
        output ack_o, insercion_o, dato_o, grant_o, ocupado_o
    );

    modport master (
        output req_i, dato_req_i, llena_i,
        input  ack_o, insercion_o, dato_o, grant_o, ocupado_o
    );
endinterface

// File: rtl/arbitro_insercion_rr.sv
// Round-robin arbiter sharing the circular buffer's single insertion port among NREQ producers,
// with an optional burst lock that keeps the winner for up to BURST consecutive words.
module arbitro_insercion_rr #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 4,
    parameter int BURST = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    arbitro_insercion_rr_if.slave bus
);
    localparam int IDX = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(BURST + 1);
    localparam logic [IDX:0]   NREQ_W  = (IDX+1)'(NREQ);
    localparam logic [IDX-1:0] ULTIMO  = IDX'(NREQ - 1);
    localparam logic [CW-1:0]  BURST_W = CW'(BURST);

    typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} estado_t;

    estado_t        estado_r, estado_n;
    logic [IDX-1:0] prioridad_r, prioridad_n;
    logic [IDX-1:0] owner_r, owner_n;
    logic [IDX-1:0] grant_r, grant_n;
    logic [CW-1:0]  cnt_r, cnt_n;

    logic [IDX-1:0]  winner_s;
    logic            hay_req_s;
    logic [IDX:0]    suma_s;
    logic [IDX-1:0]  cand_s;
    logic [NREQ-1:0] ack_s;
    logic [WIDTH-1:0] dato_s;

    function automatic logic [IDX-1:0] siguiente(input logic [IDX-1:0] v);
        return (v == ULTIMO) ? {IDX{1'b0}} : v + IDX'(1);
    endfunction

    // Winner search: descending scan so the candidate closest to prioridad_r is kept last.
    always_comb begin
        winner_s  = {IDX{1'b0}};
        hay_req_s = 1'b0;
        suma_s    = {(IDX+1){1'b0}};
        cand_s    = {IDX{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            suma_s = {1'b0, prioridad_r} + (IDX+1)'(i);
            if (suma_s >= NREQ_W) begin
                suma_s = suma_s - NREQ_W;
            end else begin
                suma_s = suma_s;
            end
            cand_s = suma_s[IDX-1:0];
            if (bus.req_i[cand_s]) begin
                winner_s  = cand_s;
                hay_req_s = 1'b1;
            end else begin
                hay_req_s = hay_req_s;
            end
        end
    end

    // Next-state and acknowledge decode.
    always_comb begin
        estado_n    = estado_r;
        prioridad_n = prioridad_r;
        owner_n     = owner_r;
        grant_n     = grant_r;
        cnt_n       = cnt_r;
        ack_s       = {NREQ{1'b0}};
        case (estado_r)
            IDLE: begin
                if (hay_req_s && !bus.llena_i) begin
                    ack_s[winner_s] = 1'b1;
                    grant_n         = winner_s;
                    if (BURST == 1) begin
                        prioridad_n = siguiente(winner_s);
                    end else begin
                        estado_n = LOCK;
                        owner_n  = winner_s;
                        cnt_n    = CW'(1);
                    end
                end else begin
                    estado_n = IDLE;
                end
            end
            LOCK: begin
                if (!bus.req_i[owner_r]) begin
                    prioridad_n = siguiente(owner_r);
                    cnt_n       = {CW{1'b0}};
                    estado_n    = IDLE;
                end else if (bus.llena_i) begin
                    estado_n = LOCK;
                end else begin
                    ack_s[owner_r] = 1'b1;
                    if ((cnt_r + CW'(1)) == BURST_W) begin
                        prioridad_n = siguiente(owner_r);
                        cnt_n       = {CW{1'b0}};
                        estado_n    = IDLE;
                    end else begin
                        cnt_n = cnt_r + CW'(1);
                    end
                end
            end
            default: begin
                estado_n = IDLE;
            end
        endcase
    end

    // Data mux: only the acknowledged producer's slice reaches the buffer.
    always_comb begin
        dato_s = {WIDTH{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            if (ack_s[k]) begin
                dato_s = bus.dato_req_i[k*WIDTH +: WIDTH];
            end else begin
                dato_s = dato_s;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            estado_r    <= IDLE;
            prioridad_r <= {IDX{1'b0}};
            owner_r     <= {IDX{1'b0}};
            grant_r     <= {IDX{1'b0}};
            cnt_r       <= {CW{1'b0}};
        end else begin
            estado_r    <= estado_n;
            prioridad_r <= prioridad_n;
            owner_r     <= owner_n;
            grant_r     <= grant_n;
            cnt_r       <= cnt_n;
        end
    end

    // Zero-latency outputs; acknowledges are held off while reset is asserted.
    always_comb begin
        if (rstn_i) begin
            bus.ack_o       = ack_s;
            bus.insercion_o = |ack_s;
            bus.dato_o      = dato_s;
        end else begin
            bus.ack_o       = {NREQ{1'b0}};
            bus.insercion_o = 1'b0;
            bus.dato_o      = {WIDTH{1'b0}};
        end
        bus.grant_o   = grant_r;
        bus.ocupado_o = (estado_r == LOCK);
    end
endmodule
